mcycle_controller: RTL and testbench
====================================

# mcycle_controller

Sequencer for the processor's multi-cycle arithmetic resource. When the control unit flags an instruction as multi-cycle (MS = 1, MCycleOp selects multiply or divide), this block latches the operands and stalls the pipeline. It runs an iterative unsigned shift-add multiply or restoring divide, then presents a two-word result for writeback. It sits beside the ALU in the execute stage and owns the stall/done handshake with the hazard logic.

## Interface
Parameters:
- WIDTH, 32, operand and result word width; the iteration count equals WIDTH.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  multi-cycle request; driven by the control unit's MS signal.
- MCycleOp  in  1  0 = unsigned multiply, 1 = unsigned divide; sampled with Start.
- Operand1  in  WIDTH  multiplicand or dividend.
- Operand2  in  WIDTH  multiplier or divisor.
- Result1  out  WIDTH  product low word, or quotient.
- Result2  out  WIDTH  product high word, or remainder.
- Busy  out  1  stall request to the pipeline.
- Done  out  1  one-cycle pulse; results are valid this cycle.

## Operation
- States: IDLE, COMPUTE, DONE. Encodings are `defines in config.v.
- IDLE:
  - Start = 1 latches Operand1, Operand2 and MCycleOp, clears the iteration counter, and moves to COMPUTE.
  - Start = 0 stays in IDLE.
- COMPUTE: performs one iteration per cycle.
  - When the counter reaches WIDTH-1, go to DONE. Otherwise increment the counter.
- DONE:
  - Done = 1, and Result1/Result2 are updated this cycle.
  - Always return to IDLE. Start is ignored in DONE, because it is the same instruction still asserting MS as it leaves the stall.
- Busy = (state == IDLE && Start) || state == COMPUTE. Busy is combinational, so the pipeline stalls in the issue cycle itself.
- Multiply (shift-add):
  - 2·WIDTH register {hi, lo}; initialise hi = 0 and lo = multiplier.
  - Each iteration: if lo[0], hi gets the (WIDTH+1)-bit sum hi + multiplicand. Then shift the whole {carry, hi, lo} right by 1.
  - Final result: Result2 = hi, Result1 = lo.
- Divide (restoring):
  - Initialise {rem, quo} = {0, dividend}.
  - Each iteration: shift {rem, quo} left by 1, then compute trial = rem − divisor at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1.
  - Final result: Result1 = quo, Result2 = rem.
- Divide by zero needs no special case. It yields Result1 = all ones and Result2 = dividend.
- Result1/Result2 hold their last values until the next DONE. Their values during COMPUTE are unspecified; the stalled pipeline does not consume them.
- Operand or MCycleOp changes after the latch cycle have no effect.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - Result1 = 0, Result2 = 0.
  - Busy = 0 (when Start = 0), Done = 0.
- Latency, with T0 as the cycle where Start is seen in IDLE:
  - COMPUTE runs T1..T(WIDTH).
  - DONE is at T(WIDTH+1).
  - Busy is high for WIDTH+1 cycles (T0..T(WIDTH)); Done is high for exactly one cycle (T(WIDTH+1)).
- Back-to-back operations: a new Start at T(WIDTH+2) is accepted at full rate. No dead cycle is needed beyond DONE.
- RESET during COMPUTE or DONE:
  - Abort at the next edge and go to IDLE.
  - Done is not asserted.
  - Results clear to 0.
- RESET has priority over Start in the same cycle.

## Structure
- config.v (shared): state encodings and the MCycleOp codes (MUL = 0, DIV = 1).
- One sub-module, mcycle_datapath, contains:
  - the 2·WIDTH working register;
  - the (WIDTH+1)-bit adder/subtractor;
  - per-iteration shift logic;
  - control inputs init, step and op.
- mcycle_controller keeps the FSM, counter, operand latch, Busy/Done and the result registers.

## Test plan
- Multiply 7 × 6 (WIDTH = 32):
  - Result1 = 42, Result2 = 0 at Done.
  - Busy high for exactly 33 cycles starting in the Start cycle.
  - Done high for 1 cycle.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF: Result1 = 0x00000001, Result2 = 0xFFFFFFFE.
- Divide:
  - 100 / 7 gives Result1 = 14, Result2 = 2.
  - 0x80000000 / 0x10 gives Result1 = 0x08000000, Result2 = 0.
- Divide 5 / 0: Result1 = 0xFFFFFFFF, Result2 = 5, with normal 33-cycle latency.
- Start in DONE and back-to-back operations:
  - Start held high through DONE: no restart, return to IDLE.
  - A second Start the following cycle (divide 9 / 2): accepted, Result1 = 4, Result2 = 1 after another 33 Busy cycles.
  - Results from the first operation hold until the second operation's Done.
- RESET mid-operation:
  - RESET pulsed at T10 of a multiply: IDLE, Busy = 0, Done = 0, results = 0 next cycle.
  - Operands changed during COMPUTE do not alter the result.

Source files
------------

// File: rtl/mcycle_controller_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// FSM state encodings and MCycleOp codes.
package mcycle_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } mc_state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_controller_datapath.sv
// Iterative datapath: 2*WIDTH working register {hi, lo} with a shared
// (WIDTH+1)-bit adder/subtractor for shift-add multiply and restoring divide.
module mcycle_datapath
  import mcycle_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] init_a,
  input  logic [WIDTH-1:0] init_b,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   add_a, add_b, sum;
  logic             is_div;

  assign is_div = (op == OP_DIV);

  // Divide subtracts the divisor from the left-shifted remainder; multiply
  // adds the multiplicand to hi with the carry kept in bit WIDTH.
  always_comb begin
    add_a = is_div ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    add_b = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
    sum   = add_a + add_b + {{WIDTH{1'b0}}, is_div};
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (init) begin
      hi_d = '0;
      lo_d = is_div ? init_a : init_b;
    end else if (step) begin
      if (!is_div) begin
        if (lo_q[0]) begin
          hi_d = sum[WIDTH:1];
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[WIDTH-1:1]};
          lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
      end else if (!sum[WIDTH]) begin
        hi_d = sum[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_nxt = hi_d;
  assign lo_nxt = lo_d;

endmodule

// File: rtl/mcycle_controller.sv
// Multi-cycle arithmetic sequencer: latches operands on Start, stalls the
// pipeline for WIDTH iterations and pulses Done with registered results.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | waiting for Start; Busy follows Start combinationally
//   ST_COMPUTE | one datapath iteration per cycle, counter 0..WIDTH-1
//   ST_DONE    | Done pulse, results valid; Start ignored, back to IDLE
module mcycle_controller
  import mcycle_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic [WIDTH-1:0] res2_q, res2_d;
  logic             done_q, done_d;

  logic             dp_init, dp_step, dp_op;
  logic [WIDTH-1:0] dp_opnd, dp_hi_nxt, dp_lo_nxt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    done_d  = 1'b0;
    dp_init = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d    = MCycleOp;
          op1_d   = Operand1;
          op2_d   = Operand2;
          cnt_d   = '0;
          dp_init = 1'b1;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        dp_step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Capture the final iteration's result so it is valid during DONE.
          res1_d  = dp_lo_nxt;
          res2_d  = dp_hi_nxt;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      op1_q   <= '0;
      op2_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
    end
  end

  // The init load comes straight from the ports; iterations use the latch.
  assign dp_op   = (state_q == ST_IDLE) ? MCycleOp : op_q;
  assign dp_opnd = (op_q == OP_DIV) ? op2_q : op1_q;

  mcycle_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (CLK),
    .rst    (RESET),
    .init   (dp_init),
    .step   (dp_step),
    .op     (dp_op),
    .init_a (Operand1),
    .init_b (Operand2),
    .opnd   (dp_opnd),
    .hi_nxt (dp_hi_nxt),
    .lo_nxt (dp_lo_nxt)
  );

  assign Busy    = ((state_q == ST_IDLE) && Start) || (state_q == ST_COMPUTE);
  assign Done    = done_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_controller.sv
// Scoreboard bench for mcycle_controller: directed multiply/divide vectors,
// back-to-back issue, Start held through DONE, and reset abort/priority.
module tb_mcycle_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_total = 0;

  mcycle_controller #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse consumes one expected result.
  always @(negedge CLK) begin
    if (Done === 1'b1) begin
      exp_t e;
      done_total++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result1", Result1, e.r1);
        chk("result2", Result2, e.r2);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after DONE.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input bit hold_start, input bit chk_hold,
                        input logic [31:0] p1, input logic [31:0] p2);
    int  busy_cnt = 0;
    int  n = 0;
    bit  seen = 0;
    exp_q.push_back('{r1: e1, r2: e2});
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    while (!seen && n < 100) begin
      @(negedge CLK);
      if (Busy) busy_cnt++;
      if (n == 16 && chk_hold) begin
        chk("hold_result1", Result1, p1);
        chk("hold_result2", Result2, p2);
      end
      if (Done) begin
        seen = 1;
      end else begin
        @(posedge CLK);
        #1;
        if (!hold_start) Start = 1'b0;
        // Inputs after the latch cycle must not matter.
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = ~op;
        n++;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'd33);
    chk("done_latency", 32'(n), 32'd33);
    @(posedge CLK);
    #1;
    chk("done_one_cycle", {31'd0, Done}, 32'd0);
  endtask

  initial begin
    int dt;
    RESET    = 1'b1;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_result1", Result1, 32'd0);
    chk("reset_result2", Result2, 32'd0);
    @(posedge CLK);
    #1;

    run_op(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 0, 0, 0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0, 0);
    @(posedge CLK);
    #1;
    run_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 0);
    run_op(1'b1, 32'h8000_0000, 32'h10, 32'h0800_0000, 32'd0, 0, 0, 0, 0);
    run_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0, 0, 0, 0);

    // Start held through DONE, then a back-to-back divide in the next cycle.
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1, 0, 0, 0);
    run_op(1'b1, 32'd9, 32'd2, 32'd4, 32'd1, 0, 1, 32'd0, 32'd1);
    chk("b2b_result1", Result1, 32'd4);

    // Reset pulsed at T10 of a multiply aborts it without a Done.
    repeat (2) @(posedge CLK);
    #1;
    dt = done_total;
    Start    = 1'b1;
    MCycleOp = 1'b0;
    Operand1 = 32'd3;
    Operand2 = 32'd5;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("busy_before_abort", {31'd0, Busy}, 32'd1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    chk("abort_result1", Result1, 32'd0);
    chk("abort_result2", Result2, 32'd0);
    repeat (40) @(posedge CLK);
    #1;
    chk("abort_no_done", 32'(done_total - dt), 32'd0);

    // RESET wins over Start in the same cycle.
    RESET = 1'b1;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    Start = 1'b0;
    @(negedge CLK);
    chk("reset_priority_busy", {31'd0, Busy}, 32'd0);

    // Normal operation still works after the abort.
    @(posedge CLK);
    #1;
    run_op(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
